// File: rtl/cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdb_arbiter: per-source result FIFOs + round-robin CDB broadcast. Rev 1.0 |
// +--------------------------------------------------------------------------+
module cdb_arbiter #(
  parameter int NSRC  = 2,
  parameter int DEPTH = 2,
  parameter int QW    = 5,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 br_flag,
  input  logic [NSRC-1:0]      src_valid_i,
  input  logic [NSRC*QW-1:0]   src_q_i,
  input  logic [NSRC*DW-1:0]   src_v_i,
  output logic [NSRC-1:0]      src_ready_o,
  output logic                 bus_en_o,
  output logic [QW-1:0]        bus_q_o,
  output logic [DW-1:0]        bus_v_o,
  output logic [NSRC-1:0]      gnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [QW-1:0]   tag_mem_q [NSRC][DEPTH];
  logic [DW-1:0]   dat_mem_q [NSRC][DEPTH];
  logic [PW-1:0]   head_q [NSRC];
  logic [PW-1:0]   head_d [NSRC];
  logic [PW-1:0]   tail_q [NSRC];
  logic [PW-1:0]   tail_d [NSRC];
  logic [CW-1:0]   cnt_q  [NSRC];
  logic [CW-1:0]   cnt_d  [NSRC];
  logic [RW-1:0]   rr_q, rr_d;
  logic            bus_en_q, bus_en_d;
  logic [QW-1:0]   bus_q_q, bus_q_d;
  logic [DW-1:0]   bus_v_q, bus_v_d;
  logic [NSRC-1:0] gnt_q, gnt_d;

  logic [NSRC-1:0] push_w;
  logic [NSRC-1:0] pop_w;
  logic            found_w;
  logic [RW-1:0]   gidx_w;

  // Tag 0 means "no dependency": accepted at the port but never stored.
  always_comb begin
    src_ready_o = '0;
    push_w      = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_ready_o[i] = en && !rst && !br_flag && (cnt_q[i] != CW'(DEPTH));
      push_w[i]      = src_valid_i[i] && src_ready_o[i] && (src_q_i[i*QW +: QW] != '0);
    end
  end

  always_comb begin
    found_w = 1'b0;
    gidx_w  = '0;
    for (int k = 1; k <= NSRC; k++) begin
      int          c;
      logic [RW-1:0] cidx;
      c = int'(rr_q) + k;
      if (c >= NSRC) c = c - NSRC;
      cidx = RW'(c);
      if (!found_w && (cnt_q[cidx] != '0)) begin
        found_w = 1'b1;
        gidx_w  = cidx;
      end
    end
  end

  always_comb begin
    pop_w = '0;
    for (int i = 0; i < NSRC; i++) begin
      pop_w[i] = en && found_w && (gidx_w == RW'(i));
    end
  end

  always_comb begin
    rr_d     = rr_q;
    bus_en_d = 1'b0;
    gnt_d    = '0;
    bus_q_d  = bus_q_q;
    bus_v_d  = bus_v_q;
    for (int i = 0; i < NSRC; i++) begin
      head_d[i] = head_q[i] + PW'(pop_w[i]);
      tail_d[i] = tail_q[i] + PW'(push_w[i]);
      cnt_d[i]  = cnt_q[i] + CW'(push_w[i]) - CW'(pop_w[i]);
    end
    if (en && found_w) begin
      bus_en_d       = 1'b1;
      bus_q_d        = tag_mem_q[gidx_w][head_q[gidx_w]];
      bus_v_d        = dat_mem_q[gidx_w][head_q[gidx_w]];
      gnt_d[gidx_w]  = 1'b1;
      rr_d           = gidx_w;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push_w[i]) begin
        tag_mem_q[i][tail_q[i]] <= src_q_i[i*QW +: QW];
        dat_mem_q[i][tail_q[i]] <= src_v_i[i*DW +: DW];
      end
    end
  end

  // Flush shares the reset path; rr restarts so source 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst || br_flag) begin
      for (int i = 0; i < NSRC; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q     <= RW'(NSRC - 1);
      bus_en_q <= 1'b0;
      bus_q_q  <= '0;
      bus_v_q  <= '0;
      gnt_q    <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      rr_q     <= rr_d;
      bus_en_q <= bus_en_d;
      bus_q_q  <= bus_q_d;
      bus_v_q  <= bus_v_d;
      gnt_q    <= gnt_d;
    end
  end

  assign bus_en_o = bus_en_q;
  assign bus_q_o  = bus_q_q;
  assign bus_v_o  = bus_v_q;
  assign gnt_o    = gnt_q;

endmodule
`default_nettype wire
